// File: rtl/mtm_alu_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mtm_alu_serializer : builds mtm_Alu response packets (result+CRC3 or error)
// and shifts them out on sout in 11-bit frames.      Rev 1.0
// ---------------------------------------------------------------------------
module mtm_alu_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_err,
    input  logic [31:0] in_c,
    input  logic [3:0]  in_flags,
    input  logic [2:0]  in_err,
    output logic        sout
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SEND   = 1'b1;
    localparam logic [5:0] C_LEN_RES = 6'd55;
    localparam logic [5:0] C_LEN_ERR = 6'd11;

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic [5:0]  r_cnt;
    logic [54:0] r_shift;
    logic        r_ready;
    logic        w_accept;
    logic        w_last;
    logic [2:0]  w_crc;
    logic [7:0]  w_ctl_res;
    logic [7:0]  w_ctl_err;
    logic [54:0] w_pkt;

    function automatic logic [10:0] frame(input logic is_ctl, input logic [7:0] d);
        return {1'b0, is_ctl, d, 1'b1};
    endfunction

    // Serial LFSR form of M(x)*x^3 mod (x^3+x+1), MSB of the message first
    function automatic logic [2:0] crc3(input logic [36:0] msg);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = msg[i] ^ c[2];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    assign w_crc     = crc3({in_c, 1'b0, in_flags});
    assign w_ctl_res = {1'b0, in_flags, w_crc};
    assign w_ctl_err = {1'b1, in_err, in_err, ^{1'b1, in_err, in_err}};
    assign w_pkt     = in_is_err ? {frame(1'b1, w_ctl_err), {44{1'b1}}}
                                 : {frame(1'b0, in_c[31:24]), frame(1'b0, in_c[23:16]),
                                    frame(1'b0, in_c[15:8]),  frame(1'b0, in_c[7:0]),
                                    frame(1'b1, w_ctl_res)};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_SEND;
            ST_SEND: if (w_last)   w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept = in_valid & r_ready;
        w_last   = (r_cnt == 6'd1);
        in_ready = r_ready;
        sout     = r_shift[54];
    end

    // Ready is registered so it stays low through reset and one cycle past it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '1;
            r_cnt   <= 6'd0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_next_state == ST_IDLE);
            if (w_accept) begin
                r_shift <= w_pkt;
                r_cnt   <= in_is_err ? C_LEN_ERR : C_LEN_RES;
            end else if (r_state == ST_SEND) begin
                r_shift <= {r_shift[53:0], 1'b1};
                r_cnt   <= r_cnt - 6'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mtm_alu_serializer : directed + random scoreboard bench for the serializer
// ---------------------------------------------------------------------------
module tb_mtm_alu_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_err;
    logic [31:0] in_c;
    logic [3:0]  in_flags;
    logic [2:0]  in_err;
    logic        sout;

    typedef struct {
        int          len;
        logic [54:0] bits;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp;
    int          n_fail;
    int          cyc;
    int          last_acc;
    int          prev_acc;
    logic [54:0] last_got;

    mtm_alu_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_is_err (in_is_err),
        .in_c      (in_c),
        .in_flags  (in_flags),
        .in_err    (in_err),
        .sout      (sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC by polynomial long division of {C,0,flags}*x^3
    function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] v;
        v = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
        return v[2:0];
    endfunction

    function automatic logic [7:0] ref_err_byte(input logic [2:0] e);
        case (e)
            3'b100:  return 8'hC9;
            3'b010:  return 8'hA5;
            3'b001:  return 8'h93;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [10:0] fr(input logic t, input logic [7:0] d);
        return {1'b0, t, d, 1'b1};
    endfunction

    task automatic scramble();
        in_is_err = 1'($urandom_range(0, 1));
        in_c      = $urandom;
        in_flags  = 4'($urandom);
        in_err    = 3'($urandom);
    endtask

    task automatic send(input logic is_err, input logic [31:0] c, input logic [3:0] f,
                        input logic [2:0] e, input bit hold, input string tag);
        exp_t        x;
        exp_t        y;
        logic [54:0] got;
        bit          rdy_bad;
        int          budget;
        if (is_err) begin
            x.len  = 11;
            x.bits = {fr(1'b1, ref_err_byte(e)), {44{1'b1}}};
        end else begin
            x.len  = 55;
            x.bits = {fr(1'b0, c[31:24]), fr(1'b0, c[23:16]), fr(1'b0, c[15:8]),
                      fr(1'b0, c[7:0]), fr(1'b1, {1'b0, f, ref_crc(c, f)})};
        end
        exp_q.push_back(x);
        in_valid  = 1'b1;
        in_is_err = is_err;
        in_c      = c;
        in_flags  = f;
        in_err    = e;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (in_ready !== 1'b1) begin
            chk({tag, "_accept_timeout"}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            y = exp_q.pop_front();
            return;
        end
        @(posedge clk); #1;
        prev_acc = last_acc;
        last_acc = cyc;
        if (!hold) in_valid = 1'b0;
        got     = '1;
        rdy_bad = 1'b0;
        for (int i = 0; i < x.len; i++) begin
            got[54-i] = sout;
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            @(posedge clk); #1;
            if (hold) scramble();
        end
        last_got = got;
        y = exp_q.pop_front();
        chk({tag, "_bits"}, 64'(got), 64'(y.bits));
        chk({tag, "_ready_low"}, 64'(rdy_bad), 64'd0);
        chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
        chk({tag, "_idle_sout"}, 64'(sout), 64'd1);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; last_acc = 0; prev_acc = 0; last_got = '1;
        rst_n = 1'b0; in_valid = 1'b0; in_is_err = 1'b0;
        in_c = '0; in_flags = '0; in_err = '0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_sout", 64'(sout), 64'd1);
            chk("rst_ready", 64'(in_ready), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("idle_sout", 64'(sout), 64'd1);
        end

        send(1'b0, 32'h0000_0000, 4'b0010, 3'b000, 1'b0, "res_zero");
        chk("res_zero_ctl", 64'(last_got[8:1]), 64'h16);
        send(1'b0, 32'h0000_0001, 4'b0000, 3'b000, 1'b0, "res_one");
        chk("res_one_data", 64'(last_got[19:12]), 64'h01);
        chk("res_one_ctl", 64'(last_got[8:1]), 64'h02);
        send(1'b0, 32'hFFFF_FFFF, 4'b1001, 3'b000, 1'b0, "res_ones");

        send(1'b1, 32'h0, 4'h0, 3'b100, 1'b0, "err_data");
        chk("err_data_byte", 64'(last_got[52:45]), 64'hC9);
        send(1'b1, 32'h0, 4'h0, 3'b010, 1'b0, "err_crc");
        chk("err_crc_byte", 64'(last_got[52:45]), 64'hA5);
        send(1'b1, 32'h0, 4'h0, 3'b001, 1'b0, "err_op");
        chk("err_op_byte", 64'(last_got[52:45]), 64'h93);

        send(1'b0, 32'hDEAD_BEEF, 4'b0101, 3'b000, 1'b1, "b2b_a");
        send(1'b0, 32'h1234_5678, 4'b1100, 3'b000, 1'b1, "b2b_b");
        chk("b2b_gap_res", 64'(last_acc - prev_acc), 64'd56);
        send(1'b1, 32'h0, 4'h0, 3'b010, 1'b0, "b2b_c");
        chk("b2b_gap_err", 64'(last_acc - prev_acc), 64'd56);

        // Abort a result packet while bit 20 is on the line
        in_valid = 1'b1; in_is_err = 1'b0; in_c = 32'h0F0F_0F0F; in_flags = 4'b0110;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_sout", 64'(sout), 64'd1);
        chk("abort_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("abort_sout2", 64'(sout), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rel_ready", 64'(in_ready), 64'd1);
        chk("abort_rel_sout", 64'(sout), 64'd1);
        send(1'b0, 32'hCAFE_F00D, 4'b0011, 3'b000, 1'b0, "post_abort");

        begin
            bit prev_hold;
            int prev_len;
            prev_hold = 1'b0;
            prev_len  = 0;
            for (int k = 0; k < 1000; k++) begin
                logic        ie;
                logic [2:0]  e;
                bit          h;
                ie = ($urandom_range(0, 3) == 0);
                e  = 3'b001 << $urandom_range(0, 2);
                h  = (k != 999) && ($urandom_range(0, 1) == 1);
                send(ie, $urandom, 4'($urandom), e, h, "rnd");
                if (prev_hold) chk("rnd_gap", 64'(last_acc - prev_acc), 64'(prev_len + 1));
                prev_hold = h;
                prev_len  = ie ? 11 : 55;
            end
        end
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
